// File: rtl/ivl_uvm_ovl_dec_pkg.sv
// Shared types and helpers for the countdown sequencer that feeds the
// decrement-style OVL checkers.
package ivl_uvm_ovl_dec_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} dec_state_e;

  // Index width that stays at least one bit for a two-requester build.
  function automatic int unsigned clog2_min1(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/ivl_uvm_ovl_rr_arb.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping around the requester ring.
module ivl_uvm_ovl_rr_arb
  import ivl_uvm_ovl_dec_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdW = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdW-1:0]     rr_ptr,
  output logic               any_req,
  output logic [IdW-1:0]     winner
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    any_req = 1'b0;
    winner  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/ivl_uvm_ovl_dec_ctrl.sv
// Countdown sequencer shared by NUM_REQ requesters; drives a monotonically
// decrementing count qualified by chk_en for OVL decrement checkers.
module ivl_uvm_ovl_dec_ctrl
  import ivl_uvm_ovl_dec_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned STEP    = 1,
  localparam int unsigned IdW    = clog2_min1(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_val,
  input  logic                     hold,
  input  logic                     abort,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [IdW-1:0]           gnt_id,
  output logic [WIDTH-1:0]         count,
  output logic                     chk_en,
  output logic                     busy,
  output logic                     done
);

  localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);

  dec_state_e       state_q, state_d;
  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]   gnt_id_q, gnt_id_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [IdW-1:0]   winner;
  logic [WIDTH-1:0] win_val;
  logic             any_req;

  ivl_uvm_ovl_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .any_req (any_req),
    .winner  (winner)
  );

  always_comb begin
    win_val = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IdW'(i)) begin
        win_val = req_val[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_id_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_id_q <= gnt_id_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (any_req) state_d = LOAD;
      LOAD: state_d = (count_q == '0) ? DONE : RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!hold && (count_q <= StepW)) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter and ownership bookkeeping; the last step saturates at zero.
  always_comb begin
    count_d  = count_q;
    gnt_id_d = gnt_id_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_id_d = winner;
          count_d  = win_val;
        end
      end
      LOAD: begin
        rr_ptr_d = (gnt_id_q == IdW'(NUM_REQ - 1)) ? '0 : gnt_id_q + IdW'(1);
      end
      RUN: begin
        if (abort) begin
          count_d = '0;
        end else if (!hold) begin
          count_d = (count_q > StepW) ? count_q - StepW : '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (state_q == LOAD) begin
      gnt[gnt_id_q] = 1'b1;
    end
    gnt_id = gnt_id_q;
    count  = count_q;
    chk_en = (state_q == RUN);
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
  end

endmodule

// File: tb/tb_ivl_uvm_ovl_dec_ctrl.sv
// Scoreboard bench for the countdown sequencer: expected per-cycle outputs are
// queued as stimulus is applied and compared on the falling edge.
module tb_ivl_uvm_ovl_dec_ctrl;

  typedef struct packed {
    logic [1:0] gnt;
    logic       gnt_id;
    logic [3:0] count;
    logic       chk_en;
    logic       busy;
    logic       done;
  } obs_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = '0, req3 = '0;
  logic [7:0] req_val = '0, req_val3 = '0;
  logic       hold = 1'b0, abort = 1'b0, hold3 = 1'b0, abort3 = 1'b0;

  logic [1:0] gnt1, gnt3;
  logic       gnt_id1, gnt_id3;
  logic [3:0] count1, count3;
  logic       chk1, chk3, busy1, busy3, done1, done3;
  obs_t       obs1, obs3;

  int   n_cmp = 0;
  int   n_err = 0;
  obs_t exp_q[$];
  bit   mon_en = 1'b0;
  logic prev_chk = 1'b0;
  logic [3:0] prev_cnt = '0;

  always #5 clock = ~clock;

  ivl_uvm_ovl_dec_ctrl #(.WIDTH(4), .NUM_REQ(2), .STEP(1)) dut (
    .clock (clock), .reset (reset), .req (req), .req_val (req_val),
    .hold (hold), .abort (abort), .gnt (gnt1), .gnt_id (gnt_id1),
    .count (count1), .chk_en (chk1), .busy (busy1), .done (done1)
  );

  ivl_uvm_ovl_dec_ctrl #(.WIDTH(4), .NUM_REQ(2), .STEP(3)) dut3 (
    .clock (clock), .reset (reset), .req (req3), .req_val (req_val3),
    .hold (hold3), .abort (abort3), .gnt (gnt3), .gnt_id (gnt_id3),
    .count (count3), .chk_en (chk3), .busy (busy3), .done (done3)
  );

  assign obs1 = {gnt1, gnt_id1, count1, chk1, busy1, done1};
  assign obs3 = {gnt3, gnt_id3, count3, chk3, busy3, done3};

  // Decrement-checker stand-in: while enabled, count only holds or steps down.
  always @(negedge clock) begin
    if (mon_en) begin
      if (prev_chk && chk1) begin
        n_cmp++;
        if (!((count1 == prev_cnt) || (prev_cnt != 4'd0 && count1 == prev_cnt - 4'd1))) begin
          n_err++;
          $display("FAIL dec_invariant: count %0d after %0d", count1, prev_cnt);
        end
      end
      n_cmp++;
      if ($countones(gnt1) > 1) begin
        n_err++;
        $display("FAIL gnt_onehot: got %b required at most one bit", gnt1);
      end
    end
    prev_chk <= chk1;
    prev_cnt <= count1;
  end

  // Expected trace of a full grant: LOAD, RUN cycles, DONE, then IDLE.
  task automatic push_countdown(input int id, input int val, input int step);
    obs_t e;
    int   c;
    e        = '0;
    e.gnt    = 2'b01 << id;
    e.gnt_id = id[0];
    e.count  = val[3:0];
    e.busy   = 1'b1;
    exp_q.push_back(e);
    e.gnt    = '0;
    e.chk_en = 1'b1;
    c        = val;
    while (c > 0) begin
      e.count = c[3:0];
      exp_q.push_back(e);
      c = (c > step) ? c - step : 0;
    end
    e.count  = '0;
    e.chk_en = 1'b0;
    e.done   = 1'b1;
    exp_q.push_back(e);
    e.done = 1'b0;
    e.busy = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (obs1 !== obs_t'('0)) begin
      n_err++;
      $display("FAIL reset_dut: got %b required %b", obs1, obs_t'('0));
    end
    n_cmp++;
    if (obs3 !== obs_t'('0)) begin
      n_err++;
      $display("FAIL reset_dut3: got %b required %b", obs3, obs_t'('0));
    end
    reset = 1'b0;
  endtask

  task automatic test_single_load();
    obs_t e;
    req     = 2'b01;
    req_val = 8'h03;
    push_countdown(0, 3, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs1 !== e) begin
        n_err++;
        $display("FAIL single_load[%0d]: got %b required %b", i, obs1, e);
      end
      if (i == 0) req = '0;
    end
  endtask

  task automatic test_saturating_step();
    obs_t e;
    req3     = 2'b01;
    req_val3 = 8'h08;
    push_countdown(0, 8, 3);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs3 !== e) begin
        n_err++;
        $display("FAIL saturating_step[%0d]: got %b required %b", i, obs3, e);
      end
      if (i == 0) req3 = '0;
    end
  endtask

  task automatic test_round_robin();
    obs_t e;
    do_reset();
    req     = 2'b11;
    req_val = 8'h12;
    for (int k = 0; k < 8; k++) begin
      push_countdown(k % 2, (k % 2 == 1) ? 1 : 2, 1);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs1 !== e) begin
        n_err++;
        $display("FAIL round_robin[%0d]: got %b required %b", i, obs1, e);
      end
    end
    req = '0;
  endtask

  task automatic test_hold_abort();
    obs_t e;
    req     = 2'b10;
    req_val = 8'h60;
    exp_q.push_back(obs_t'({2'b10, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0}));
    exp_q.push_back(obs_t'({2'b00, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0}));
    exp_q.push_back(obs_t'({2'b00, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0}));
    for (int k = 0; k < 4; k++) exp_q.push_back(obs_t'({2'b00, 1'b1, 4'd4, 1'b1, 1'b1, 1'b0}));
    for (int k = 0; k < 2; k++) exp_q.push_back(obs_t'({2'b00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0}));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs1 !== e) begin
        n_err++;
        $display("FAIL hold_abort[%0d]: got %b required %b", i, obs1, e);
      end
      if (i == 0) req = '0;
      hold  = (i >= 3 && i <= 5);
      abort = (i == 6);
    end
  endtask

  task automatic test_zero_and_reset();
    obs_t e;
    // Abort held through a zero load must not suppress the done pulse.
    req     = 2'b01;
    req_val = 8'h00;
    abort   = 1'b1;
    push_countdown(0, 0, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs1 !== e) begin
        n_err++;
        $display("FAIL zero_load[%0d]: got %b required %b", i, obs1, e);
      end
      if (i == 0) req = '0;
    end
    abort   = 1'b0;
    req     = 2'b01;
    req_val = 8'h09;
    push_countdown(0, 9, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs1 !== e) begin
        n_err++;
        $display("FAIL pre_reset_run[%0d]: got %b required %b", i, obs1, e);
      end
      if (i == 0) req = '0;
    end
    exp_q.delete();
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (obs1 !== obs_t'('0)) begin
      n_err++;
      $display("FAIL mid_run_reset: got %b required %b", obs1, obs_t'('0));
    end
    reset   = 1'b0;
    req     = 2'b11;
    req_val = 8'h21;
    push_countdown(0, 1, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs1 !== e) begin
        n_err++;
        $display("FAIL post_reset_grant[%0d]: got %b required %b", i, obs1, e);
      end
      if (i == 0) req = '0;
    end
  endtask

  task automatic test_checker_hookup();
    mon_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      req     = 2'($urandom_range(0, 3));
      req_val = 8'($urandom);
      hold    = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 15) == 0);
    end
    req   = '0;
    hold  = 1'b0;
    abort = 1'b0;
    repeat (20) @(negedge clock);
    mon_en = 1'b0;
    n_cmp++;
    if (busy1 !== 1'b0) begin
      n_err++;
      $display("FAIL random_drain: busy %b required 0", busy1);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_saturating_step();
    test_round_robin();
    test_hold_abort();
    test_zero_and_reset();
    test_checker_hookup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
